tff_mod_counter: RTL

- Synchronous modulo up/down counter built from T-type storage cells.
- Each cell toggles when its T input is high; the per-bit T vector is generated combinationally from the current count, direction and modulo boundary.
- Sits directly upstream of T flip-flop consumers: its tc output is the T/enable input for the next counter or divider stage.
- Also serves as the general-purpose event/divide counter in the sequential library.

---
 rtl/tff_pkg.sv | 8 +
 rtl/tff_cell.sv | 23 ++
 rtl/tff_mod_counter.sv | 79 +++++++
 3 files changed

// File: rtl/tff_pkg.sv
// Shared constants for the T-cell based modulo counter.
package tff_pkg;

    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/tff_cell.sv
// Single T storage cell with synchronous clear and parallel load.
module tff_cell
    import tff_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo up/down counter; the next state is expressed as a per-bit toggle vector into T cells.
module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;

    logic [WIDTH-1:0] q_eff;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] ld_clamped;
    logic             wrap_next;

    // Out-of-range counts behave as MAX so the counter always recovers in one step.
    assign q_eff      = (q > MAX_V) ? MAX_V : q;
    assign ld_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (en) begin
            if (up == DIR_UP) begin
                if (q_eff == MAX_V) begin
                    q_next    = ZERO_V;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_eff + 1'b1;
                end
            end else begin
                if (q_eff == ZERO_V) begin
                    q_next    = MAX_V;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_eff - 1'b1;
                end
            end
        end
        t_vec = q ^ q_next;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t_vec[i]),
            .ld    (load),
            .d     (ld_clamped[i]),
            .q     (q[i])
        );
    end

    assign tc = en & ~load & (((up == DIR_UP) & (q == MAX_V)) |
                              ((up == DIR_DOWN) & (q == ZERO_V)));

    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            wrap <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

endmodule
